// File: rtl/piso_tx_pkg.sv
// Shared definitions for the piso_tx serialiser: state encoding, default
// word length and the bit-counter width helper.
package piso_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must index 0..width-1; keep it at least one bit wide.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: loads a word on a valid/ready
// handshake and shifts it out LSB first, one bit per clock, with a strobe.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_rdy_en;
  logic             w_shift;
  logic             w_last;
  logic             w_accept;

  // Handshake: a word transfers on a rising edge where ld_valid and
  // ld_ready are both 1; ld_ready depends only on registered state, so the
  // source may wait on it, and ld_valid/ld_data are ignored while it is 0.
  assign w_shift   = (r_state == SHIFT);
  assign w_last    = w_shift && (r_cnt == LAST_CNT);
  assign ld_ready  = r_rdy_en && (!w_shift || w_last);
  assign w_accept  = ld_valid && ld_ready;

  assign sdo       = w_shift & r_sr[0];
  assign sdo_valid = w_shift;
  assign busy      = w_shift;
  assign done      = w_last;

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_sr_nxt    = ld_data;
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        w_sr_nxt  = {1'b0, r_sr[WIDTH-1:1]};
        w_cnt_nxt = r_cnt + 1'b1;
        // Reload in the last-bit cycle keeps the line busy with no gap.
        if (w_accept) begin
          w_sr_nxt  = ld_data;
          w_cnt_nxt = '0;
        end else if (w_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      r_state  <= IDLE;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sr     <= w_sr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rdy_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a right-shift receiver model plus a queue-based
// reference model of the serial line for the WIDTH=4 instance.
`timescale 1ns/1ps

module sipo_rx_model #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) q <= '0;
    else if (sdi_valid) q <= {sdi, q[WIDTH-1:1]};
  end
endmodule

module tb_piso_tx;

  logic       clk = 1'b0;
  logic       clrb = 1'b1;
  logic       ld_valid4 = 1'b0;
  logic [3:0] ld_data4 = '0;
  logic       ld_ready4, sdo4, sdo_valid4, busy4, done4;
  logic       ld_valid8 = 1'b0;
  logic [7:0] ld_data8 = '0;
  logic       ld_ready8, sdo8, sdo_valid8, busy8, done8;
  logic [3:0] rx_q4;
  logic [7:0] rx_q8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4)) dut4 (
    .clk(clk), .clrb(clrb), .ld_valid(ld_valid4), .ld_data(ld_data4),
    .ld_ready(ld_ready4), .sdo(sdo4), .sdo_valid(sdo_valid4),
    .busy(busy4), .done(done4)
  );

  piso_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .clrb(clrb), .ld_valid(ld_valid8), .ld_data(ld_data8),
    .ld_ready(ld_ready8), .sdo(sdo8), .sdo_valid(sdo_valid8),
    .busy(busy8), .done(done8)
  );

  sipo_rx_model #(.WIDTH(4)) rx4 (
    .clk(clk), .clrb(clrb), .sdi(sdo4), .sdi_valid(sdo_valid4), .q(rx_q4)
  );

  sipo_rx_model #(.WIDTH(8)) rx8 (
    .clk(clk), .clrb(clrb), .sdi(sdo8), .sdi_valid(sdo_valid8), .q(rx_q8)
  );

  // Reference model: the line is a queue of pending bits, each tagged with
  // whether it is the last bit of its word; a word can be taken whenever at
  // most one bit is still pending.
  logic       exp_q[$];
  logic       last_q[$];
  logic [3:0] word_q[$];
  logic       m_en;
  logic       rx_chk;
  logic [3:0] rx_exp;

  function automatic logic m_ready();
    return m_en && (exp_q.size() <= 1);
  endfunction

  function automatic logic [4:0] m_outs();
    logic act;
    act = (exp_q.size() > 0);
    return {m_ready(), act ? exp_q[0] : 1'b0, act, act, act ? last_q[0] : 1'b0};
  endfunction

  task automatic m_reset();
    exp_q.delete();
    last_q.delete();
    word_q.delete();
    m_en   = 1'b0;
    rx_chk = 1'b0;
    rx_exp = '0;
  endtask

  task automatic m_edge(input logic v, input logic [3:0] d);
    logic acc;
    logic was_last;
    acc    = v && m_ready();
    rx_chk = 1'b0;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      was_last = last_q.pop_front();
      if (was_last) begin
        rx_exp = word_q.pop_front();
        rx_chk = 1'b1;
      end
    end
    if (acc) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(d[i]);
        last_q.push_back(i == 3);
      end
      word_q.push_back(d);
    end
    m_en = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    m_reset();
    clrb = 1'b1;
    #1 clrb = 1'b0;
    @(negedge clk);
    got = {ld_ready4, sdo4, sdo_valid4, busy4, done4};
    n_checks++;
    if (got !== 5'b0) begin n_fail++; $display("FAIL reset_w4 got=%b exp=%b", got, 5'b0); end
    got = {ld_ready8, sdo8, sdo_valid8, busy8, done8};
    n_checks++;
    if (got !== 5'b0) begin n_fail++; $display("FAIL reset_w8 got=%b exp=%b", got, 5'b0); end
    clrb = 1'b1;
    #1;
    n_checks++;
    if (ld_ready4 !== 1'b0) begin n_fail++; $display("FAIL ready_at_release got=%b exp=0", ld_ready4); end
    @(posedge clk); m_edge(1'b0, 4'b0);
    @(negedge clk);
    n_checks++;
    if (ld_ready4 !== 1'b1) begin n_fail++; $display("FAIL ready_after_release got=%b exp=1", ld_ready4); end
    n_checks++;
    if (ld_ready8 !== 1'b1) begin n_fail++; $display("FAIL ready8_after_release got=%b exp=1", ld_ready8); end
    // Abort a word in flight with an asynchronous reset.
    ld_valid4 = 1'b1; ld_data4 = 4'b1011;
    @(posedge clk); m_edge(ld_valid4, ld_data4);
    @(negedge clk);
    ld_valid4 = 1'b0;
    got = {ld_ready4, sdo4, sdo_valid4, busy4, done4};
    n_checks++;
    if (got !== m_outs()) begin n_fail++; $display("FAIL midword_pre got=%b exp=%b", got, m_outs()); end
    @(posedge clk); m_edge(ld_valid4, ld_data4);
    #2 clrb = 1'b0;
    m_reset();
    #1;
    got = {ld_ready4, sdo4, sdo_valid4, busy4, done4};
    n_checks++;
    if (got !== 5'b0) begin n_fail++; $display("FAIL midword_async got=%b exp=%b", got, 5'b0); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      got = {ld_ready4, sdo4, sdo_valid4, busy4, done4};
      n_checks++;
      if (got !== 5'b0) begin n_fail++; $display("FAIL midword_hold c%0d got=%b exp=%b", c, got, 5'b0); end
    end
    clrb = 1'b1;
    #1;
    n_checks++;
    if (ld_ready4 !== 1'b0) begin n_fail++; $display("FAIL ready_at_release2 got=%b exp=0", ld_ready4); end
    @(posedge clk); m_edge(1'b0, 4'b0);
    @(negedge clk);
    got = {ld_ready4, sdo4, sdo_valid4, busy4, done4};
    n_checks++;
    if (got !== m_outs()) begin n_fail++; $display("FAIL after_abort got=%b exp=%b", got, m_outs()); end
  endtask

  task automatic test_single();
    logic [4:0] got;
    logic [3:0] lit;
    int         n_done;
    lit    = 4'b1011;
    n_done = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      ld_valid4 = (c == 0); ld_data4 = 4'b1011;
      got = {ld_ready4, sdo4, sdo_valid4, busy4, done4};
      n_checks++;
      if (got !== m_outs()) begin n_fail++; $display("FAIL single c%0d got=%b exp=%b", c, got, m_outs()); end
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if ({sdo4, done4, ld_ready4} !== {lit[c-1], c == 4, c == 4})
          begin n_fail++; $display("FAIL single_lit c%0d got=%b exp=%b", c, {sdo4, done4, ld_ready4}, {lit[c-1], c == 4, c == 4}); end
      end
      if (done4) n_done++;
      @(posedge clk); m_edge(ld_valid4, ld_data4);
    end
    ld_valid4 = 1'b0;
    n_checks++;
    if (n_done !== 1) begin n_fail++; $display("FAIL single_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  got;
    logic [15:0] seq, vmask, dmask;
    int          nb;
    seq = '0; vmask = '0; dmask = '0; nb = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ld_valid4 = (c == 0) || (c == 4);
      ld_data4  = (c == 0) ? 4'b1011 : 4'b0110;
      got = {ld_ready4, sdo4, sdo_valid4, busy4, done4};
      n_checks++;
      if (got !== m_outs()) begin n_fail++; $display("FAIL b2b c%0d got=%b exp=%b", c, got, m_outs()); end
      vmask[c] = sdo_valid4;
      dmask[c] = done4;
      if (sdo_valid4 && nb < 16) begin seq[nb] = sdo4; nb++; end
      @(posedge clk); m_edge(ld_valid4, ld_data4);
    end
    ld_valid4 = 1'b0;
    n_checks++;
    if (seq[7:0] !== 8'b0110_1011) begin n_fail++; $display("FAIL b2b_bits got=%b exp=%b", seq[7:0], 8'b0110_1011); end
    n_checks++;
    if (vmask !== 16'h01FE) begin n_fail++; $display("FAIL b2b_valid_mask got=%h exp=%h", vmask, 16'h01FE); end
    n_checks++;
    if (dmask !== 16'h0110) begin n_fail++; $display("FAIL b2b_done_mask got=%h exp=%h", dmask, 16'h0110); end
  endtask

  task automatic test_load_busy();
    logic [4:0]  got;
    logic [15:0] seq, vmask, dmask;
    int          nb;
    seq = '0; vmask = '0; dmask = '0; nb = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ld_valid4 = (c == 0) || (c == 2);
      ld_data4  = (c == 0) ? 4'b0001 : 4'b1111;
      got = {ld_ready4, sdo4, sdo_valid4, busy4, done4};
      n_checks++;
      if (got !== m_outs()) begin n_fail++; $display("FAIL busy_load c%0d got=%b exp=%b", c, got, m_outs()); end
      vmask[c] = sdo_valid4;
      dmask[c] = done4;
      if (sdo_valid4 && nb < 16) begin seq[nb] = sdo4; nb++; end
      @(posedge clk); m_edge(ld_valid4, ld_data4);
    end
    ld_valid4 = 1'b0;
    n_checks++;
    if ({nb[4:0], seq[3:0]} !== {5'd4, 4'b0001}) begin n_fail++; $display("FAIL busy_load_bits got=%0d/%b exp=4/0001", nb, seq[3:0]); end
    n_checks++;
    if (vmask !== 16'h001E) begin n_fail++; $display("FAIL busy_load_valid_mask got=%h exp=%h", vmask, 16'h001E); end
    n_checks++;
    if (dmask !== 16'h0010) begin n_fail++; $display("FAIL busy_load_done_mask got=%h exp=%h", dmask, 16'h0010); end
  endtask

  task automatic test_loopback();
    logic [4:0] got;
    int         n_rx;
    n_rx = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      ld_valid4 = (c == 0) || (c == 4) || (c == 10);
      ld_data4  = (c == 0) ? 4'b1001 : (c == 4) ? 4'b0100 : 4'b1111;
      got = {ld_ready4, sdo4, sdo_valid4, busy4, done4};
      n_checks++;
      if (got !== m_outs()) begin n_fail++; $display("FAIL loop c%0d got=%b exp=%b", c, got, m_outs()); end
      if (rx_chk) begin
        n_rx++;
        n_checks++;
        if (rx_q4 !== rx_exp) begin n_fail++; $display("FAIL loop_rx c%0d got=%b exp=%b", c, rx_q4, rx_exp); end
      end
      @(posedge clk); m_edge(ld_valid4, ld_data4);
    end
    ld_valid4 = 1'b0;
    n_checks++;
    if (n_rx !== 3) begin n_fail++; $display("FAIL loop_word_count got=%0d exp=3", n_rx); end
  endtask

  task automatic test_random();
    logic [4:0] got;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      ld_valid4 = 1'($urandom_range(0, 1));
      ld_data4  = 4'($urandom_range(0, 15));
      got = {ld_ready4, sdo4, sdo_valid4, busy4, done4};
      n_checks++;
      if (got !== m_outs()) begin n_fail++; $display("FAIL random c%0d got=%b exp=%b", c, got, m_outs()); end
      if (rx_chk) begin
        n_checks++;
        if (rx_q4 !== rx_exp) begin n_fail++; $display("FAIL random_rx c%0d got=%b exp=%b", c, rx_q4, rx_exp); end
      end
      @(posedge clk); m_edge(ld_valid4, ld_data4);
    end
    @(negedge clk);
    ld_valid4 = 1'b0;
    @(posedge clk); m_edge(ld_valid4, ld_data4);
  endtask

  task automatic test_width8();
    logic [7:0] words[2];
    logic [7:0] w;
    logic [4:0] got, exp;
    words[0] = 8'hA5;
    words[1] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 2; k++) begin
      w = words[k];
      @(negedge clk);
      n_checks++;
      if (ld_ready8 !== 1'b1) begin n_fail++; $display("FAIL w8_ready_idle k%0d got=%b exp=1", k, ld_ready8); end
      ld_valid8 = 1'b1; ld_data8 = w;
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        ld_valid8 = 1'b0;
        got = {sdo8, sdo_valid8, done8, busy8, ld_ready8};
        exp = (c <= 8) ? {w[c-1], 1'b1, c == 8, 1'b1, c == 8} : 5'b00001;
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL w8 k%0d c%0d got=%b exp=%b", k, c, got, exp); end
      end
      n_checks++;
      if (rx_q8 !== w) begin n_fail++; $display("FAIL w8_rx k%0d got=%h exp=%h", k, rx_q8, w); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_load_busy();
    test_loopback();
    test_random();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
